// File: rtl/dma_pcis_rd_responder_if.sv
// dma_pcis_rd_responder_if: AXI4 read address/data channels plus the output-FIFO head seen by the responder
interface dma_pcis_rd_responder_if #(
    parameter int DATA_W = 512,
    parameter int ID_W   = 6,
    parameter int LVL_W  = 10
);
    logic              arvalid;
    logic              arready;
    logic [ID_W-1:0]   arid;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic              rvalid;
    logic              rready;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              fifo_valid;
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_rd_en;
    logic [LVL_W-1:0]  fifo_level;
    modport slave (
        input  arvalid, arid, arlen, arsize, rready, fifo_valid, fifo_dout, fifo_level,
        output arready, rvalid, rid, rdata, rresp, rlast, fifo_rd_en
    );
    modport master (
        output arvalid, arid, arlen, arsize, rready, fifo_valid, fifo_dout, fifo_level,
        input  arready, rvalid, rid, rdata, rresp, rlast, fifo_rd_en
    );
endinterface

// File: rtl/dma_pcis_rd_responder.sv
// dma_pcis_rd_responder: single-burst AXI4 read slave streaming whole bursts out of the output FIFO
module dma_pcis_rd_responder #(
    parameter int DATA_W = 512,
    parameter int ID_W   = 6,
    parameter int LVL_W  = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    dma_pcis_rd_responder_if.slave  bus,
    output logic                    busy,
    output logic [15:0]             burst_cnt
);
    localparam logic [2:0] SIZE_OK = 3'($clog2(DATA_W / 8));
    typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;
    state_t          state, state_n;
    logic [ID_W-1:0] id_q;
    logic [7:0]      len_q;
    logic            err_q;
    logic            ok_q;
    logic [8:0]      beats_left;
    logic            ar_hs, last_hs, issue, lvl_ok;
    always_comb begin
        ar_hs          = state == IDLE && bus.arvalid && bus.arready;
        last_hs        = state == BURST && bus.rvalid && bus.rready && bus.rlast;
        issue          = state == BURST && beats_left != 9'd0 && (!bus.rvalid || bus.rready) && (err_q || bus.fifo_valid);
        // one extra bit so a 256-beat burst compares without overflow
        lvl_ok         = {1'b0, bus.fifo_level} >= (LVL_W + 1)'(len_q) + (LVL_W + 1)'(1);
        state_n        = state == IDLE ? (ar_hs ? WAIT : IDLE) :
                         state == WAIT ? (ok_q ? BURST : WAIT) :
                                         (last_hs ? IDLE : BURST);
        bus.fifo_rd_en = issue && !err_q;
        busy           = state != IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            bus.arready <= 1'b0;
            bus.rvalid  <= 1'b0;
            bus.rlast   <= 1'b0;
            bus.rid     <= '0;
            bus.rresp   <= 2'b00;
            bus.rdata   <= '0;
            id_q        <= '0;
            len_q       <= '0;
            err_q       <= 1'b0;
            ok_q        <= 1'b0;
            beats_left  <= '0;
            burst_cnt   <= '0;
        end else begin
            state       <= state_n;
            bus.arready <= state_n == IDLE;
            if (ar_hs) begin
                id_q       <= bus.arid;
                len_q      <= bus.arlen;
                err_q      <= bus.arsize != SIZE_OK;
                ok_q       <= 1'b0;
                beats_left <= {1'b0, bus.arlen} + 9'd1;
            end
            // the occupancy check is registered, so BURST starts two cycles after AR at the earliest
            if (state == WAIT) ok_q <= err_q || lvl_ok;
            if (issue) begin
                bus.rvalid <= 1'b1;
                bus.rdata  <= err_q ? '0 : bus.fifo_dout;
                bus.rresp  <= err_q ? 2'b10 : 2'b00;
                bus.rid    <= id_q;
                bus.rlast  <= beats_left == 9'd1;
                beats_left <= beats_left - 9'd1;
            end else if (bus.rvalid && bus.rready) begin
                bus.rvalid <= 1'b0;
                if (bus.rlast) begin
                    bus.rlast <= 1'b0;
                    burst_cnt <= burst_cnt + 16'd1;
                end
            end
        end
    end
endmodule
